// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller
// Brief    : Prioritised interrupt request generator (machine timer plus
//            NUM_EXT edge-triggered external lines) with a hold-until-ack
//            handshake towards the core. Optional macro IRQ_SYNC_EN adds a
//            2-flop synchronizer on every external line.
// Revision : 1.0 - initial release
// ============================================================================
module irq_controller #(
    parameter int NUM_EXT = 4,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_EXT-1:0] ext_irq_i,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    input  logic               irq_ack,
    output logic [1:0]         interrupt,
    output logic [3:0]         irq_id
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    localparam logic [1:0] C_IRQ_NONE  = 2'b00;
    localparam logic [1:0] C_IRQ_TIMER = 2'b01;
    localparam logic [1:0] C_IRQ_EXT   = 2'b10;

    state_t               state_q, state_d;
    logic [1:0]           interrupt_q, interrupt_d;
    logic [3:0]           irq_id_q, irq_id_d;
    logic [31:0]          mtime_q, mtime_d;
    logic [31:0]          mtimecmp_q, mtimecmp_d;
    logic [PRESC_W-1:0]   prescale_q, prescale_d;
    logic [PRESC_W-1:0]   presc_cnt_q, presc_cnt_d;
    logic                 timer_armed_q, timer_armed_d;
    logic [NUM_EXT-1:0]   enable_q, enable_d;
    logic [NUM_EXT-1:0]   pending_q, pending_d;
    logic [NUM_EXT-1:0]   ext_prev_q, ext_prev_d;

    logic [NUM_EXT-1:0]   ext_s;
    logic [NUM_EXT-1:0]   ext_rise;
    logic [NUM_EXT-1:0]   ext_req_vec;
    logic [NUM_EXT-1:0]   ack_clr;
    logic [NUM_EXT-1:0]   w1c_mask;
    logic                 timer_req;
    logic                 ext_req;
    logic                 ack_taken;
    logic [3:0]           ext_sel;

`ifdef IRQ_SYNC_EN
    logic [NUM_EXT-1:0]   sync1_q, sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ext_irq_i;
            sync2_q <= sync1_q;
        end
    end

    assign ext_s = sync2_q;
`else
    assign ext_s = ext_irq_i;
`endif

    assign ext_prev_d  = ext_s;
    assign ext_rise    = ext_s & ~ext_prev_q;
    assign ext_req_vec = pending_q & enable_q;
    assign ext_req     = |ext_req_vec;
    assign timer_req   = timer_armed_q && (mtime_q >= mtimecmp_q);
    assign ack_taken   = (state_q == ST_ASSERT) && irq_ack;

    // Lowest enabled pending index wins among external sources.
    always_comb begin
        ext_sel = 4'd0;
        for (int i = NUM_EXT - 1; i >= 0; i--) begin
            if (ext_req_vec[i]) begin
                ext_sel = 4'(i);
            end
        end
    end

    always_comb begin
        presc_cnt_d = presc_cnt_q + PRESC_W'(1);
        mtime_d     = mtime_q;
        if (presc_cnt_q >= prescale_q) begin
            presc_cnt_d = '0;
            mtime_d     = mtime_q + 32'd1;
        end
    end

    // A mtimecmp write in the same cycle as a timer ack re-arms the timer.
    always_comb begin
        mtimecmp_d    = mtimecmp_q;
        enable_d      = enable_q;
        prescale_d    = prescale_q;
        w1c_mask      = '0;
        timer_armed_d = timer_armed_q;
        if (ack_taken && (interrupt_q == C_IRQ_TIMER)) begin
            timer_armed_d = 1'b0;
        end
        if (cfg_we) begin
            case (cfg_addr)
                2'd0: begin
                    mtimecmp_d    = cfg_wdata;
                    timer_armed_d = 1'b1;
                end
                2'd1:    enable_d   = cfg_wdata[NUM_EXT-1:0];
                2'd2:    prescale_d = cfg_wdata[PRESC_W-1:0];
                default: w1c_mask   = cfg_wdata[NUM_EXT-1:0];
            endcase
        end
    end

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_EXT; i++) begin
            ack_clr[i] = ack_taken && (interrupt_q == C_IRQ_EXT) && (irq_id_q == 4'(i));
        end
    end

    // New edges take precedence over both W1C and ack clearing.
    assign pending_d = (pending_q & ~w1c_mask & ~ack_clr) | ext_rise;

    always_comb begin
        state_d     = state_q;
        interrupt_d = interrupt_q;
        irq_id_d    = irq_id_q;
        case (state_q)
            ST_IDLE: begin
                if (ext_req) begin
                    state_d     = ST_ASSERT;
                    interrupt_d = C_IRQ_EXT;
                    irq_id_d    = ext_sel;
                end else if (timer_req) begin
                    state_d     = ST_ASSERT;
                    interrupt_d = C_IRQ_TIMER;
                    irq_id_d    = 4'd0;
                end
            end
            ST_ASSERT: begin
                if (irq_ack) begin
                    state_d     = ST_GAP;
                    interrupt_d = C_IRQ_NONE;
                    irq_id_d    = 4'd0;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                interrupt_d = C_IRQ_NONE;
                irq_id_d    = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            interrupt_q   <= C_IRQ_NONE;
            irq_id_q      <= 4'd0;
            mtime_q       <= 32'd0;
            mtimecmp_q    <= 32'hFFFF_FFFF;
            prescale_q    <= '0;
            presc_cnt_q   <= '0;
            timer_armed_q <= 1'b1;
            enable_q      <= '0;
            pending_q     <= '0;
            ext_prev_q    <= '0;
        end else begin
            state_q       <= state_d;
            interrupt_q   <= interrupt_d;
            irq_id_q      <= irq_id_d;
            mtime_q       <= mtime_d;
            mtimecmp_q    <= mtimecmp_d;
            prescale_q    <= prescale_d;
            presc_cnt_q   <= presc_cnt_d;
            timer_armed_q <= timer_armed_d;
            enable_q      <= enable_d;
            pending_q     <= pending_d;
            ext_prev_q    <= ext_prev_d;
        end
    end

    always_comb begin
        case (cfg_addr)
            2'd0:    cfg_rdata = mtime_q;
            2'd1:    cfg_rdata = 32'(enable_q);
            2'd2:    cfg_rdata = 32'(prescale_q);
            default: cfg_rdata = 32'(pending_q);
        endcase
    end

    assign interrupt = interrupt_q;
    assign irq_id    = irq_id_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_controller
// Brief    : Randomised scoreboard bench for irq_controller against a
//            behavioural model of timer, pending bits and request handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

    localparam int NUM_EXT = 4;
    localparam int PRESC_W = 8;
`ifdef IRQ_SYNC_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_EXT-1:0] ext_irq_i;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic [31:0]        cfg_wdata;
    logic [31:0]        cfg_rdata;
    logic               irq_ack;
    logic [1:0]         interrupt;
    logic [3:0]         irq_id;

    irq_controller #(.NUM_EXT(NUM_EXT), .PRESC_W(PRESC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .ext_irq_i (ext_irq_i),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .irq_ack   (irq_ack),
        .interrupt (interrupt),
        .irq_id    (irq_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int         cyc;
        logic [1:0] irq;
        logic [3:0] id;
    } exp_t;
    exp_t sbq[$];

    // Reference model state
    logic [31:0]        m_mtime, m_cmp;
    logic               m_armed;
    int                 m_presc, m_cnt;
    logic [NUM_EXT-1:0] m_en, m_pend;
    logic [NUM_EXT-1:0] m_hist[4];
    logic [1:0]         m_out;
    logic [3:0]         m_id;
    int                 m_gap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mtime = 32'd0;
        m_cmp   = 32'hFFFF_FFFF;
        m_armed = 1'b1;
        m_presc = 0;
        m_cnt   = 0;
        m_en    = '0;
        m_pend  = '0;
        for (int k = 0; k < 4; k++) m_hist[k] = '0;
        m_out   = 2'b00;
        m_id    = 4'd0;
        m_gap   = 0;
    endtask

    function automatic logic [31:0] model_rdata(input logic [1:0] a);
        case (a)
            2'd0:    return m_mtime;
            2'd1:    return 32'(m_en);
            2'd2:    return 32'(m_presc);
            default: return 32'(m_pend);
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [NUM_EXT-1:0] rise, req, ackclr, w1c;
        logic [1:0] n_out;
        logic [3:0] n_id;
        logic       tmr_req, armed_n;
        int         sel;
        for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = ext_irq_i;
        rise    = m_hist[SYNC_STAGES] & ~m_hist[SYNC_STAGES+1];
        req     = m_pend & m_en;
        tmr_req = m_armed && (m_mtime >= m_cmp);
        sel = -1;
        for (int i = 0; i < NUM_EXT; i++) if (req[i] && sel < 0) sel = i;
        ackclr  = '0;
        w1c     = '0;
        armed_n = m_armed;
        n_out   = m_out;
        n_id    = m_id;
        if (m_out != 2'b00) begin
            if (irq_ack) begin
                if (m_out == 2'b10) ackclr[m_id] = 1'b1;
                else                armed_n = 1'b0;
                n_out = 2'b00;
                n_id  = 4'd0;
                m_gap = 1;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (sel >= 0) begin
            n_out = 2'b10;
            n_id  = 4'(sel);
        end else if (tmr_req) begin
            n_out = 2'b01;
            n_id  = 4'd0;
        end
        if (m_cnt >= m_presc) begin
            m_cnt   = 0;
            m_mtime = m_mtime + 32'd1;
        end else begin
            m_cnt++;
        end
        if (cfg_we) begin
            case (cfg_addr)
                2'd0: begin m_cmp = cfg_wdata; armed_n = 1'b1; end
                2'd1: m_en    = cfg_wdata[NUM_EXT-1:0];
                2'd2: m_presc = int'(cfg_wdata[PRESC_W-1:0]);
                default: w1c  = cfg_wdata[NUM_EXT-1:0];
            endcase
        end
        m_pend  = (m_pend & ~w1c & ~ackclr) | rise;
        m_armed = armed_n;
        if (n_out != m_out || n_id != m_id) sbq.push_back('{cyc + 1, n_out, n_id});
        m_out = n_out;
        m_id  = n_id;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("cfg_rdata", cfg_rdata, model_rdata(cfg_addr));
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_req(input int maxc);
        int k = 0;
        while (m_out == 2'b00 && k < maxc) begin
            tick();
            k++;
        end
        if (m_out == 2'b00) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_req: no request within %0d cycles, expected one", maxc);
        end
    endtask

    task automatic ack_after(input int delay);
        cycles(delay);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic do_reset(input bit check_drop);
        reset = 1'b1;
        #1;
        if (check_drop) begin
            check("async_drop_irq", 32'(interrupt), 32'd0);
            check("async_drop_id", 32'(irq_id), 32'd0);
        end
        model_reset();
        sbq.delete();
        cfg_we = 1'b0; irq_ack = 1'b0; cfg_addr = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_mtime", cfg_rdata, 32'd0);
        check("reset_irq", 32'(interrupt), 32'd0);
        check("reset_id", 32'(irq_id), 32'd0);
        reset = 1'b0;
    endtask

    // Monitor: every change of the request outputs must match the next
    // scoreboard entry, including the cycle it was predicted for.
    initial begin
        logic [1:0] last_irq;
        logic [3:0] last_id;
        exp_t e;
        last_irq = 2'b00;
        last_id  = 4'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_irq = 2'b00;
                last_id  = 4'd0;
            end else begin
                if (interrupt !== last_irq || irq_id !== last_id) begin
                    vectors++;
                    if (sbq.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_change: got irq=%b id=%0d at cyc %0d, expected no change",
                                 interrupt, irq_id, cyc);
                    end else begin
                        e = sbq.pop_front();
                        if (e.cyc != cyc || e.irq !== interrupt || e.id !== irq_id) begin
                            miscompares++;
                            $display("FAIL irq_event: got irq=%b id=%0d cyc %0d, expected irq=%b id=%0d cyc %0d",
                                     interrupt, irq_id, cyc, e.irq, e.id, e.cyc);
                        end
                    end
                    last_irq = interrupt;
                    last_id  = irq_id;
                end
                while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                    e = sbq.pop_front();
                    vectors++;
                    miscompares++;
                    $display("FAIL missed_event: got irq=%b id=%0d, expected irq=%b id=%0d at cyc %0d",
                             interrupt, irq_id, e.irq, e.id, e.cyc);
                end
            end
        end
    end

    initial begin
        int lat;
        int b;
        reset = 1'b1; ext_irq_i = '0; cfg_we = 1'b0; cfg_addr = 2'd0;
        cfg_wdata = 32'd0; irq_ack = 1'b0;
        model_reset();
        do_reset(1'b0);

        for (int k = 1; k <= 3; k++) begin
            tick();
            check("mtime_count", cfg_rdata, 32'(k));
        end

        // Timer fires at mtimecmp, held until ack, re-arms on mtimecmp write.
        cfg_write(2'd2, 32'd0);
        cfg_write(2'd0, 32'd20);
        wait_req(60);
        ack_after(3);
        cycles(10);
        cfg_write(2'd0, 32'd40);
        wait_req(60);
        ack_after(1);
        cycles(4);

        // External edge on line 2; a held level must not re-fire.
        cfg_write(2'd1, 32'h4);
        ext_irq_i[2] = 1'b1;
        wait_req(10);
        ack_after(2);
        cfg_addr = 2'd3;
        cycles(10);
        check("pend_after_ack", cfg_rdata, 32'd0);
        ext_irq_i[2] = 1'b0;

        // Timer and external due together: external first, then timer.
        cfg_write(2'd1, 32'h2);
        ext_irq_i[1] = 1'b1;
        cycles(SYNC_STAGES);
        cfg_write(2'd0, m_mtime);
        wait_req(10);
        ack_after(1);
        wait_req(10);
        ack_after(1);
        cycles(4);
        ext_irq_i[1] = 1'b0;

        // Masked edge stays pending; enabling it raises the request; W1C while held.
        cfg_write(2'd1, 32'h0);
        ext_irq_i[3] = 1'b1;
        cfg_addr = 2'd3;
        cycles(6);
        check("masked_pending", cfg_rdata, 32'h8);
        cfg_write(2'd1, 32'h8);
        wait_req(10);
        cfg_write(2'd3, 32'h8);
        cycles(3);
        ack_after(0);
        cycles(6);
        ext_irq_i = '0;
        cfg_write(2'd1, 32'h0);

        // Reset while a timer request is asserted.
        cfg_write(2'd0, m_mtime + 32'd5);
        wait_req(20);
        do_reset(1'b1);
        cycles(20);
        check("no_timer_after_reset", 32'(interrupt), 32'd0);

        // Edge-to-pending latency.
        ext_irq_i[0] = 1'b1;
        cfg_addr = 2'd3;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (cfg_rdata[0] && lat == 0) lat = k;
        end
        check("edge_latency", 32'(lat), 32'(SYNC_STAGES + 1));
        ext_irq_i[0] = 1'b0;

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                b = $urandom_range(0, NUM_EXT - 1);
                ext_irq_i[b] = ~ext_irq_i[b];
            end
            cfg_we   = ($urandom_range(0, 19) == 0);
            cfg_addr = 2'($urandom_range(0, 3));
            case (cfg_addr)
                2'd0:    cfg_wdata = m_mtime + 32'($urandom_range(0, 40));
                2'd2:    cfg_wdata = 32'($urandom_range(0, 3));
                default: cfg_wdata = $urandom;
            endcase
            if (m_out != 2'b00) irq_ack = ($urandom_range(0, 3) == 0);
            else                irq_ack = ($urandom_range(0, 31) == 0);
            tick();
        end
        cfg_we = 1'b0;
        irq_ack = 1'b0;

        for (int n = 0; n < 200; n++) begin
            irq_ack = (m_out != 2'b00);
            tick();
        end
        irq_ack = 1'b0;
        cycles(5);

        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d outstanding events, expected 0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
